// File: rtl/inst_fetch_resp_if.sv
// rtl/inst_fetch_resp_if.sv - PC, instruction-memory and decode handshake bundle for inst_fetch_resp
interface inst_fetch_resp_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] pc_i;
    logic              pc_valid_i;
    logic              pc_ready_o;
    logic              flush_i;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              inst_valid_o;
    logic [DATA_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_addr_o;
    logic              inst_err_o;
    logic              inst_ready_i;

    modport slave (
        input  pc_i, pc_valid_i, flush_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, inst_ready_i,
        output pc_ready_o, mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o, inst_err_o
    );

    modport master (
        output pc_i, pc_valid_i, flush_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, inst_ready_i,
        input  pc_ready_o, mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o, inst_err_o
    );
endinterface

// File: rtl/inst_fetch_resp.sv
// rtl/inst_fetch_resp.sv - in-order instruction fetch responder with credit, flush and misalign handling
module inst_fetch_resp #(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              DEPTH     = 2,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_resp_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    logic [ADDR_W-1:0] aq_mem_q [DEPTH];
    logic [ADDR_W-1:0] aq_mem_d [DEPTH];
    entry_t            fifo_mem_q [DEPTH];
    entry_t            fifo_mem_d [DEPTH];
    ptr_t aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
    ptr_t fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    cnt_t aq_cnt_q, aq_cnt_d, fifo_cnt_q, fifo_cnt_d;
    cnt_t outstanding_q, outstanding_d, drop_q, drop_d;

    logic           credit, aligned, can_go, mem_req, acc_mem, acc_mis;
    logic           rsp, push_rsp, fifo_push, fifo_pop, fifo_valid;
    cnt_t           live;
    logic [CNT_W:0] occupancy;
    entry_t         push_entry, head;

    // Credit, acceptance, queue and counter next-state; flush overrides everything
    always_comb begin
        live       = outstanding_q - drop_q;
        occupancy  = {1'b0, live} + {1'b0, fifo_cnt_q};
        credit     = occupancy < (CNT_W+1)'(DEPTH);
        aligned    = bus.pc_i[1:0] == 2'b00;
        can_go     = ~rst & bus.pc_valid_i & credit & ~bus.flush_i;
        mem_req    = can_go & aligned;
        acc_mem    = mem_req & bus.mem_gnt_i;
        // misaligned fetches wait for earlier memory fetches so order is preserved
        acc_mis    = can_go & ~aligned & (aq_cnt_q == '0);
        rsp        = bus.mem_rvalid_i;
        push_rsp   = rsp & (drop_q == '0) & ~bus.flush_i;
        fifo_valid = fifo_cnt_q != '0;
        fifo_pop   = fifo_valid & bus.inst_ready_i;
        fifo_push  = push_rsp | acc_mis;
        head       = fifo_mem_q[fifo_rd_q];

        if (push_rsp) begin
            push_entry = '{err: 1'b0, data: bus.mem_rdata_i, addr: aq_mem_q[aq_rd_q]};
        end else begin
            push_entry = '{err: 1'b1, data: NOP_INSTR, addr: bus.pc_i};
        end

        outstanding_d = outstanding_q + cnt_t'(acc_mem) - cnt_t'(rsp);
        drop_d        = drop_q;
        aq_mem_d      = aq_mem_q;
        aq_wr_d       = aq_wr_q;
        aq_rd_d       = aq_rd_q;
        aq_cnt_d      = aq_cnt_q;
        fifo_mem_d    = fifo_mem_q;
        fifo_wr_d     = fifo_wr_q;
        fifo_rd_d     = fifo_rd_q;
        fifo_cnt_d    = fifo_cnt_q;

        if (bus.flush_i) begin
            // every response still owed by memory belongs to the old path
            drop_d     = outstanding_q - cnt_t'(rsp);
            aq_wr_d    = '0;
            aq_rd_d    = '0;
            aq_cnt_d   = '0;
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            fifo_cnt_d = '0;
        end else begin
            if (rsp && drop_q != '0) begin
                drop_d = drop_q - cnt_t'(1);
            end
            if (acc_mem) begin
                aq_mem_d[aq_wr_q] = bus.pc_i;
                aq_wr_d           = aq_wr_q + ptr_t'(1);
            end
            if (push_rsp) begin
                aq_rd_d = aq_rd_q + ptr_t'(1);
            end
            aq_cnt_d = aq_cnt_q + cnt_t'(acc_mem) - cnt_t'(push_rsp);
            if (fifo_push) begin
                fifo_mem_d[fifo_wr_q] = push_entry;
                fifo_wr_d             = fifo_wr_q + ptr_t'(1);
            end
            if (fifo_pop) begin
                fifo_rd_d = fifo_rd_q + ptr_t'(1);
            end
            fifo_cnt_d = fifo_cnt_q + cnt_t'(fifo_push) - cnt_t'(fifo_pop);
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= '0;
            drop_q        <= '0;
            aq_wr_q       <= '0;
            aq_rd_q       <= '0;
            aq_cnt_q      <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            aq_wr_q       <= aq_wr_d;
            aq_rd_q       <= aq_rd_d;
            aq_cnt_q      <= aq_cnt_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    // Queue storage; contents are only meaningful behind valid counts, so no reset
    always_ff @(posedge clk) begin
        aq_mem_q   <= aq_mem_d;
        fifo_mem_q <= fifo_mem_d;
    end

    // Counters must never wrap and memory must never answer unrequested reads
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(acc_mem && !rsp && outstanding_q == {CNT_W{1'b1}}));
            assert (!(rsp && outstanding_q == '0));
        end
    end

    assign bus.mem_req_o    = mem_req;
    assign bus.mem_addr_o   = mem_req ? bus.pc_i : '0;
    assign bus.pc_ready_o   = acc_mem | acc_mis;
    assign bus.inst_valid_o = fifo_valid;
    assign bus.inst_o       = fifo_valid ? head.data : '0;
    assign bus.inst_addr_o  = fifo_valid ? head.addr : '0;
    assign bus.inst_err_o   = fifo_valid & head.err;
endmodule
